// File: rtl/ccsds_123b2_output_stream_checker_if.sv
// Receive-side AXI-stream bundle between the compressor output and the checker.
interface ccsds_123b2_output_stream_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] axis_in_d;
  logic                  axis_in_valid;
  logic                  axis_in_last;
  logic                  axis_in_ready;

  // Source of the stream (compressor output or bench driver).
  modport master (
    output axis_in_d,
    output axis_in_valid,
    output axis_in_last,
    input  axis_in_ready
  );

  // Sink of the stream (the checker).
  modport slave (
    input  axis_in_d,
    input  axis_in_valid,
    input  axis_in_last,
    output axis_in_ready
  );
endinterface

// File: rtl/ccsds_123b2_output_stream_checker.sv
// Output stream checker: consumes the compressed bitstream under a rotating
// ready pattern, accumulates word count and modular checksum, and reports
// pass / count mismatch / checksum mismatch / overrun-or-timeout.
module ccsds_123b2_output_stream_checker #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          REF_WORD_COUNT = 4881,
  parameter logic [63:0] REF_CHECKSUM   = 64'h0004360006B58000,
  parameter int          TIMEOUT_CYCLES = 217500,
  parameter logic [7:0]  READY_PATTERN  = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  ccsds_123b2_output_stream_checker_if.slave     axis,
  output logic                                   busy,
  output logic                                   finished,
  output logic                                   failed,
  output logic                                   timeout,
  output logic [1:0]                             fail_code,
  output logic [31:0]                            word_count,
  output logic [DATA_WIDTH-1:0]                  checksum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_PASS     = 2'd0,
    FC_COUNT    = 2'd1,
    FC_CHECKSUM = 2'd2,
    FC_OVERRUN  = 2'd3
  } fail_code_e;

  localparam logic [31:0]           REF_COUNT  = 32'(REF_WORD_COUNT);
  localparam logic [DATA_WIDTH-1:0] REF_SUM    = REF_CHECKSUM[DATA_WIDTH-1:0];
  localparam logic [31:0]           TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [31:0]           word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [31:0]           timer_q, timer_d;
  logic [7:0]            pattern_q, pattern_d;
  logic                  ready_q, ready_d;
  fail_code_e            fail_code_q, fail_code_d;
  logic                  timeout_q, timeout_d;

  logic                  in_receive;
  logic                  start_ok;
  logic                  xfer;
  logic [31:0]           count_inc;
  logic [DATA_WIDTH-1:0] sum_inc;
  logic                  term_last;
  logic                  term_overrun;
  logic                  expire;
  logic                  run_end;
  logic [7:0]            pattern_rot;

  // Handshake and termination conditions for the current cycle.
  assign in_receive   = (state_q == S_RECEIVE);
  assign start_ok     = start && !in_receive;
  assign xfer         = in_receive && axis.axis_in_valid && ready_q;
  assign count_inc    = word_count_q + 32'd1;
  assign sum_inc      = checksum_q + axis.axis_in_d;
  assign term_last    = xfer && axis.axis_in_last;
  assign term_overrun = xfer && !axis.axis_in_last && (count_inc == REF_COUNT);
  // A terminating transfer in the expiry cycle takes precedence over the timeout.
  assign expire       = in_receive && (timer_q == TIMER_LAST) && !(term_last || term_overrun);
  assign run_end      = term_last || term_overrun || expire;
  assign pattern_rot  = {pattern_q[0], pattern_q[7:1]};

  // FSM state register.
  // NOTE: async reset belongs in the sensitivity list; all state uses <= so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start)   state_d = S_RECEIVE;
      S_RECEIVE: if (run_end) state_d = S_DONE;
      S_DONE:    if (start)   state_d = S_RECEIVE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM-decoded status outputs.
  always_comb begin
    busy     = 1'b0;
    finished = 1'b0;
    failed   = 1'b0;
    unique case (state_q)
      S_RECEIVE: busy = 1'b1;
      S_DONE: begin
        finished = 1'b1;
        failed   = (fail_code_q != FC_PASS);
      end
      default: ;
    endcase
  end

  // Datapath next-state: counters, checksum, ready pattern and verdict.
  always_comb begin
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    timer_d      = timer_q;
    pattern_d    = pattern_q;
    ready_d      = 1'b0;
    fail_code_d  = fail_code_q;
    timeout_d    = timeout_q;

    if (start_ok) begin
      word_count_d = '0;
      checksum_d   = '0;
      timer_d      = '0;
      pattern_d    = READY_PATTERN;
      ready_d      = READY_PATTERN[0];
      fail_code_d  = FC_PASS;
      timeout_d    = 1'b0;
    end else if (in_receive) begin
      pattern_d = pattern_rot;
      timer_d   = timer_q + 32'd1;
      // Ready is registered from the pattern, so it never depends on valid.
      ready_d   = pattern_rot[0] && !run_end;

      if (xfer) begin
        word_count_d = count_inc;
        checksum_d   = sum_inc;
      end

      if (term_last) begin
        if (count_inc != REF_COUNT)  fail_code_d = FC_COUNT;
        else if (sum_inc != REF_SUM) fail_code_d = FC_CHECKSUM;
        else                         fail_code_d = FC_PASS;
      end else if (term_overrun) begin
        fail_code_d = FC_OVERRUN;
      end else if (expire) begin
        fail_code_d = FC_OVERRUN;
        timeout_d   = 1'b1;
      end
    end
  end

  // Datapath registers; reset clears everything so an aborted run leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q <= '0;
      checksum_q   <= '0;
      timer_q      <= '0;
      pattern_q    <= READY_PATTERN;
      ready_q      <= 1'b0;
      fail_code_q  <= FC_PASS;
      timeout_q    <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      timer_q      <= timer_d;
      pattern_q    <= pattern_d;
      ready_q      <= ready_d;
      fail_code_q  <= fail_code_d;
      timeout_q    <= timeout_d;
    end
  end

  assign axis.axis_in_ready = ready_q;
  assign timeout            = timeout_q;
  assign fail_code          = fail_code_q;
  assign word_count         = word_count_q;
  assign checksum           = checksum_q;

endmodule

// File: tb/tb_ccsds_123b2_output_stream_checker.sv
// Scoreboard bench: two checker instances (ready pattern FF and 55) share one
// stimulus driver; a monitor compares the final status against queued
// expectations each time finished rises.
module tb_ccsds_123b2_output_stream_checker;

  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]  fc;
    logic        failed;
    logic        timeout;
    logic [31:0] wc;
    logic [15:0] cs;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Shared stimulus, routed to the selected instance.
  logic          sel     = 1'b0;
  logic [DW-1:0] s_d     = '0;
  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic          s_start = 1'b0;

  logic        busy_a, fin_a, failed_a, to_a, busy_b, fin_b, failed_b, to_b;
  logic [1:0]  fc_a, fc_b;
  logic [31:0] wc_a, wc_b;
  logic [15:0] cs_a, cs_b;

  ccsds_123b2_output_stream_checker_if #(.DATA_WIDTH(DW)) if_a ();
  ccsds_123b2_output_stream_checker_if #(.DATA_WIDTH(DW)) if_b ();

  assign if_a.axis_in_d     = s_d;
  assign if_a.axis_in_valid = s_valid && !sel;
  assign if_a.axis_in_last  = s_last;
  assign if_b.axis_in_d     = s_d;
  assign if_b.axis_in_valid = s_valid && sel;
  assign if_b.axis_in_last  = s_last;

  ccsds_123b2_output_stream_checker #(
    .DATA_WIDTH(DW), .REF_WORD_COUNT(4), .REF_CHECKSUM(64'd10),
    .TIMEOUT_CYCLES(50), .READY_PATTERN(8'hFF)
  ) dut_a (
    .clk(clk), .rst(rst), .start(s_start && !sel), .axis(if_a),
    .busy(busy_a), .finished(fin_a), .failed(failed_a), .timeout(to_a),
    .fail_code(fc_a), .word_count(wc_a), .checksum(cs_a)
  );

  ccsds_123b2_output_stream_checker #(
    .DATA_WIDTH(DW), .REF_WORD_COUNT(4), .REF_CHECKSUM(64'd10),
    .TIMEOUT_CYCLES(50), .READY_PATTERN(8'b0101_0101)
  ) dut_b (
    .clk(clk), .rst(rst), .start(s_start && sel), .axis(if_b),
    .busy(busy_b), .finished(fin_b), .failed(failed_b), .timeout(to_b),
    .fail_code(fc_b), .word_count(wc_b), .checksum(cs_b)
  );

  // Outputs of the selected instance.
  logic        ready_m, busy_m, fin_m, failed_m, to_m;
  logic [1:0]  fc_m;
  logic [31:0] wc_m;
  logic [15:0] cs_m;
  assign ready_m  = sel ? if_b.axis_in_ready : if_a.axis_in_ready;
  assign busy_m   = sel ? busy_b   : busy_a;
  assign fin_m    = sel ? fin_b    : fin_a;
  assign failed_m = sel ? failed_b : failed_a;
  assign to_m     = sel ? to_b     : to_a;
  assign fc_m     = sel ? fc_b     : fc_a;
  assign wc_m     = sel ? wc_b     : wc_a;
  assign cs_m     = sel ? cs_b     : cs_a;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  result_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: on each rising edge of finished, pop and compare the verdict.
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    if (fin_m && !fin_prev) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_finish");
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("fail_code",  64'(fc_m),     64'(e.fc));
        check("failed",     64'(failed_m), 64'(e.failed));
        check("timeout",    64'(to_m),     64'(e.timeout));
        check("word_count", 64'(wc_m),     64'(e.wc));
        check("checksum",   64'(cs_m),     64'(e.cs));
      end
    end
    fin_prev <= fin_m;
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done;
    done    = 1'b0;
    s_d     = d;
    s_valid = 1'b1;
    s_last  = l;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ready_m) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) fail_now("send_wait_ready");
  endtask

  task automatic wait_finished(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (fin_m) done = 1'b1;
    end
    if (!done) fail_now(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int seen_ready;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", 64'(if_a.axis_in_ready), 64'd0);
    check("rst_ready_b", 64'(if_b.axis_in_ready), 64'd0);
    check("rst_busy",     64'(busy_m),   64'd0);
    check("rst_finished", 64'(fin_m),    64'd0);
    check("rst_failed",   64'(failed_m), 64'd0);
    check("rst_timeout",  64'(to_m),     64'd0);
    check("rst_fc",       64'(fc_m),     64'd0);
    check("rst_wc",       64'(wc_m),     64'd0);
    check("rst_cs",       64'(cs_m),     64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Pass: 1,2,3,4 back to back with ready held high.
    exp_q.push_back('{fc: 2'd0, failed: 1'b0, timeout: 1'b0, wc: 32'd4, cs: 16'd10});
    pulse_start();
    check("busy_in_receive", 64'(busy_m), 64'd1);
    c0 = cyc;
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b1);
    s_valid = 1'b0;
    check("pass_cycles", 64'(cyc - c0), 64'd4);
    wait_finished("pass_finish");
    check("done_ready_low", 64'(ready_m), 64'd0);

    // Checksum mismatch.
    exp_q.push_back('{fc: 2'd2, failed: 1'b1, timeout: 1'b0, wc: 32'd4, cs: 16'd11});
    pulse_start();
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd5, 1'b1);
    s_valid = 1'b0;
    wait_finished("sum_finish");

    // Count mismatch: last on the second word.
    exp_q.push_back('{fc: 2'd1, failed: 1'b1, timeout: 1'b0, wc: 32'd2, cs: 16'd3});
    pulse_start();
    send(16'd1, 1'b0); send(16'd2, 1'b1);
    s_valid = 1'b0;
    wait_finished("count_finish");

    // Overrun, restarted from DONE: four words with no last; fifth is refused.
    exp_q.push_back('{fc: 2'd3, failed: 1'b1, timeout: 1'b0, wc: 32'd4, cs: 16'd10});
    pulse_start();
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
    s_d = 16'd5; s_valid = 1'b1; s_last = 1'b0;
    seen_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready_m) seen_ready++;
    end
    check("overrun_fifth_ready", 64'(seen_ready), 64'd0);
    check("overrun_wc_held", 64'(wc_m), 64'd4);
    s_valid = 1'b0;
    @(posedge clk); #1;

    // Timeout: no input; finished appears 50 cycles after start.
    exp_q.push_back('{fc: 2'd3, failed: 1'b1, timeout: 1'b1, wc: 32'd0, cs: 16'd0});
    pulse_start();
    c0 = 0;
    while (!fin_m && c0 < 100) begin
      @(posedge clk); #1;
      c0++;
    end
    check("timeout_cycles", 64'(c0), 64'd50);

    // Asynchronous reset after two words, then a clean run.
    pulse_start();
    send(16'd1, 1'b0); send(16'd2, 1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",  64'(busy_m),  64'd0);
    check("mid_rst_ready", 64'(ready_m), 64'd0);
    check("mid_rst_wc",    64'(wc_m),    64'd0);
    check("mid_rst_cs",    64'(cs_m),    64'd0);
    check("mid_rst_fin",   64'(fin_m),   64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{fc: 2'd0, failed: 1'b0, timeout: 1'b0, wc: 32'd4, cs: 16'd10});
    pulse_start();
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b1);
    s_valid = 1'b0;
    wait_finished("post_rst_finish");

    // Last word lands on the expiry edge (timer = 49): transfer wins.
    exp_q.push_back('{fc: 2'd0, failed: 1'b0, timeout: 1'b0, wc: 32'd4, cs: 16'd10});
    pulse_start();
    repeat (46) @(posedge clk);
    #1;
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b1);
    s_valid = 1'b0;
    wait_finished("expiry_finish");

    // Back-pressure pattern 0101_0101 on the second instance.
    sel = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{fc: 2'd0, failed: 1'b0, timeout: 1'b0, wc: 32'd4, cs: 16'd10});
    pulse_start();
    c0 = cyc;
    send(16'd1, 1'b0);
    check("bp_ready_low", 64'(ready_m), 64'd0);
    s_d = 16'h00FF; s_last = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_glitch_not_sampled", 64'(wc_m), 64'd1);
    send(16'd2, 1'b0);
    check("bp_ready_toggle", 64'(ready_m), 64'd0);
    send(16'd3, 1'b0); send(16'd4, 1'b1);
    s_valid = 1'b0;
    check("bp_cycles", 64'(cyc - c0), 64'd7);
    wait_finished("bp_finish");

    // Drain the scoreboard.
    c0 = 0;
    while (exp_q.size() != 0 && c0 < 20) begin
      @(posedge clk); #1;
      c0++;
    end
    if (exp_q.size() != 0) fail_now("scoreboard_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
